mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_access_unit.sv | 122 ++++++++++++
 tb/tb_mem_access_unit.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Bundles the MEM-stage request, the result and the data-memory word port of mem_access_unit.
interface mem_access_unit_if;
    localparam int unsigned DATA_W = 32;

    // MEM-stage request
    logic              req_valid;
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        size;
    logic              sign_ext;
    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] store_data;

    // data memory word port
    logic              dm_readEn;
    logic              dm_writeEn;
    logic [DATA_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_WriteData;
    logic [DATA_W-1:0] dm_ReadData;

    // pipeline-facing results
    logic              stall;
    logic [DATA_W-1:0] load_data;
    logic              load_valid;
    logic              misalign_err;

    // Access unit side
    modport slave (
        input  req_valid, mem_read, mem_write, size, sign_ext, address, store_data,
        input  dm_ReadData,
        output dm_readEn, dm_writeEn, dm_address, dm_WriteData,
        output stall, load_data, load_valid, misalign_err
    );

    // Pipeline + data memory side
    modport master (
        output req_valid, mem_read, mem_write, size, sign_ext, address, store_data,
        output dm_ReadData,
        input  dm_readEn, dm_writeEn, dm_address, dm_WriteData,
        input  stall, load_data, load_valid, misalign_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: word-port data memory, big-endian lanes,
// sub-word stores via a one-stall read-modify-write, registered load results.
module mem_access_unit (
    input  logic            clk,
    input  logic            rst,
    mem_access_unit_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned HALF_W = 16;

    typedef enum logic {IDLE, RMW_WRITE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   merged_q;
    logic [DATA_W-1:0]   load_data_q;
    logic                load_valid_q;
    logic                misalign_q;

    logic                misaligned_c;
    logic                active_c;
    logic                is_store_c;
    logic                is_load_c;
    logic                sub_store_c;
    logic                word_store_c;
    logic [DATA_W-1:0]   merged_c;
    logic [DATA_W-1:0]   load_ext_c;
    logic [BYTE_W-1:0]   lane_byte_c;
    logic [HALF_W-1:0]   lane_half_c;

    // Request decode; only meaningful in IDLE, RMW_WRITE ignores the request inputs
    always_comb begin
        misaligned_c = 1'b0;
        case (bus.size)
            2'b00:   misaligned_c = 1'b0;
            2'b01:   misaligned_c = bus.address[0];
            2'b10:   misaligned_c = |bus.address[1:0];
            default: misaligned_c = 1'b1;
        endcase
        active_c     = (state == IDLE) && bus.req_valid && (bus.mem_read || bus.mem_write);
        is_store_c   = active_c && bus.mem_write && !misaligned_c;
        is_load_c    = active_c && bus.mem_read && !bus.mem_write && !misaligned_c;
        sub_store_c  = is_store_c && (bus.size != 2'b10);
        word_store_c = is_store_c && (bus.size == 2'b10);
    end

    // Merge the store lane(s) into the word read back from memory (lane 0 is the MSB byte)
    always_comb begin
        merged_c = bus.dm_ReadData;
        case (bus.size)
            2'b00: begin
                case (bus.address[1:0])
                    2'b00:   merged_c[31:24] = bus.store_data[7:0];
                    2'b01:   merged_c[23:16] = bus.store_data[7:0];
                    2'b10:   merged_c[15:8]  = bus.store_data[7:0];
                    default: merged_c[7:0]   = bus.store_data[7:0];
                endcase
            end
            2'b01: begin
                if (bus.address[1]) merged_c[15:0]  = bus.store_data[15:0];
                else                merged_c[31:16] = bus.store_data[15:0];
            end
            default: merged_c = bus.dm_ReadData;
        endcase
    end

    // Extract the addressed lane of the read word and extend it to a full word
    always_comb begin
        case (bus.address[1:0])
            2'b00:   lane_byte_c = bus.dm_ReadData[31:24];
            2'b01:   lane_byte_c = bus.dm_ReadData[23:16];
            2'b10:   lane_byte_c = bus.dm_ReadData[15:8];
            default: lane_byte_c = bus.dm_ReadData[7:0];
        endcase
        lane_half_c = bus.address[1] ? bus.dm_ReadData[15:0] : bus.dm_ReadData[31:16];
        case (bus.size)
            2'b00:   load_ext_c = bus.sign_ext
                                  ? {{(DATA_W-BYTE_W){lane_byte_c[BYTE_W-1]}}, lane_byte_c}
                                  : DATA_W'(lane_byte_c);
            2'b01:   load_ext_c = bus.sign_ext
                                  ? {{(DATA_W-HALF_W){lane_half_c[HALF_W-1]}}, lane_half_c}
                                  : DATA_W'(lane_half_c);
            default: load_ext_c = bus.dm_ReadData;
        endcase
    end

    // FSM and registered results; reset abandons any pending RMW write
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            merged_q     <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            load_valid_q <= is_load_c;
            misalign_q   <= active_c && misaligned_c;
            if (is_load_c) load_data_q <= load_ext_c;
            case (state)
                IDLE: begin
                    if (sub_store_c) begin
                        merged_q <= merged_c;
                        state    <= RMW_WRITE;
                    end
                end
                RMW_WRITE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    // Memory strobes and stall are same-cycle; all gated off while in reset
    assign bus.dm_address   = {bus.address[31:2], 2'b00};
    assign bus.dm_readEn    = !rst && (is_load_c || sub_store_c);
    assign bus.dm_writeEn   = !rst && (word_store_c || (state == RMW_WRITE));
    assign bus.dm_WriteData = (state == RMW_WRITE) ? merged_q : bus.store_data;
    assign bus.stall        = !rst && sub_store_c;
    assign bus.load_data    = load_data_q;
    assign bus.load_valid   = load_valid_q;
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, reset corner cases and
// random traffic checked against a byte-addressed big-endian memory model.
module tb_mem_access_unit;
    logic clk;
    logic rst;

    mem_access_unit_if bus ();

    mem_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Word-organised data memory attached to the DUT
    logic [31:0] tb_mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    assign bus.dm_ReadData = tb_mem[bus.dm_address[9:2]];

    always @(posedge clk) begin
        if (pl_en) tb_mem[pl_idx] <= pl_data;
        else if (bus.dm_writeEn) tb_mem[bus.dm_address[9:2]] <= bus.dm_WriteData;
    end

    // Reference model: byte array, lower address holds the more significant byte
    logic [7:0]  ref_b [0:1023];
    logic [31:0] last_load;

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        logic [9:0] w;
        w = {a[9:2], 2'b00};
        return {ref_b[w], ref_b[w+10'd1], ref_b[w+10'd2], ref_b[w+10'd3]};
    endfunction

    function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sx, input logic [31:0] a);
        logic [9:0]  i;
        logic [15:0] h;
        i = a[9:0];
        h = {ref_b[i], ref_b[i+10'd1]};
        if (sz == 2'd0) return sx ? 32'(signed'(ref_b[i])) : 32'(ref_b[i]);
        if (sz == 2'd1) return sx ? 32'(signed'(h)) : 32'(h);
        return ref_word(a);
    endfunction

    task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        logic [9:0] i;
        i = a[9:0];
        if (sz == 2'd0) ref_b[i] = d[7:0];
        else if (sz == 2'd1) begin
            ref_b[i] = d[15:8]; ref_b[i+10'd1] = d[7:0];
        end else begin
            ref_b[i] = d[31:24]; ref_b[i+10'd1] = d[23:16];
            ref_b[i+10'd2] = d[15:8]; ref_b[i+10'd3] = d[7:0];
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Read and write strobes must never overlap
    always @(negedge clk) begin
        if (!rst && bus.dm_readEn === 1'b1 && bus.dm_writeEn === 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_overlap: got readEn=1 writeEn=1 expected not both at %0t", $time);
        end
    end

    // One request (or idle cycle) through the unit, checked against the model
    task automatic do_req(input logic rv, input logic mr, input logic mw, input logic [1:0] sz,
                          input logic sx, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] got_res, output logic got_stall, output logic got_mis);
        logic mis, st, ld, sub;
        logic [31:0] exp_ld, exp_w;
        got_res = 32'd0;
        @(negedge clk);
        bus.req_valid = rv; bus.mem_read = mr; bus.mem_write = mw;
        bus.size = sz; bus.sign_ext = sx; bus.address = a; bus.store_data = d;
        #1;
        mis = ref_mis(sz, a);
        st  = rv && mw && !mis;
        ld  = rv && mr && !mw && !mis;
        sub = st && (sz != 2'd2);
        exp_ld = ld ? ref_load(sz, sx, a) : last_load;
        chk("dm_address", bus.dm_address, {a[31:2], 2'b00});
        chk("dm_readEn", 32'(bus.dm_readEn), 32'(ld || sub));
        chk("dm_writeEn", 32'(bus.dm_writeEn), 32'(st && !sub));
        chk("stall", 32'(bus.stall), 32'(sub));
        got_stall = bus.stall;
        if (st && !sub) begin
            chk("word_wdata", bus.dm_WriteData, d);
            got_res = bus.dm_WriteData;
            ref_store(sz, a, d);
        end
        @(posedge clk); #1;
        chk("misalign_err", 32'(bus.misalign_err), 32'(rv && (mr || mw) && mis));
        got_mis = bus.misalign_err;
        chk("load_valid", 32'(bus.load_valid), 32'(ld));
        chk("load_data", bus.load_data, exp_ld);
        last_load = exp_ld;
        if (ld) got_res = bus.load_data;
        if (sub) begin
            ref_store(sz, a, d);
            exp_w = ref_word(a);
            chk("rmw_writeEn", 32'(bus.dm_writeEn), 32'd1);
            chk("rmw_readEn", 32'(bus.dm_readEn), 32'd0);
            chk("rmw_stall", 32'(bus.stall), 32'd0);
            chk("rmw_wdata", bus.dm_WriteData, exp_w);
            got_res = bus.dm_WriteData;
            @(posedge clk); #1;
            chk("rmw_load_valid", 32'(bus.load_valid), 32'd0);
            chk("rmw_misalign", 32'(bus.misalign_err), 32'd0);
        end
    endtask

    typedef struct {
        logic        mr;
        logic        mw;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_mis;
        logic        exp_stall;
        logic [31:0] exp_res;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] res, w, a, d;
        logic        gs, gm, rv, mr, mw, sx;
        logic [1:0]  sz;
        int          nbad;

        vecs[0]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h406, 32'h000000AB, 1'b0, 1'b1, 32'h1122AB44};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h406, 32'h0,        1'b0, 1'b0, 32'h000000AB};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h409, 32'h0,        1'b0, 1'b0, 32'hFFFFFFFF};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h40A, 32'h0,        1'b0, 1'b0, 32'h00007F01};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h401, 32'h5555,     1'b1, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, 2'd3, 1'b0, 32'h400, 32'h12345678, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h408, 32'h0,        1'b0, 1'b0, 32'hFFFF80FF};
        vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h40A, 32'h12345678, 1'b0, 1'b1, 32'h80FF5678};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h40C, 32'hCAFEF00D, 1'b0, 1'b0, 32'hCAFEF00D};
        vecs[10] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h408, 32'h0,        1'b0, 1'b0, 32'h00000080};
        vecs[11] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h402, 32'h0,        1'b1, 1'b0, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h40F, 32'h0,        1'b0, 1'b0, 32'h0000000D};
        vecs[13] = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h40E, 32'h0,        1'b0, 1'b0, 32'hFFFFF00D};
        vecs[14] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h404, 32'h0,        1'b0, 1'b0, 32'h1122AB44};

        // Reset held while memory is preloaded; a word store is presented meanwhile
        rst = 1'b1; pl_en = 1'b0; pl_idx = 8'd0; pl_data = 32'd0;
        bus.req_valid = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
        bus.size = 2'd2; bus.sign_ext = 1'b0; bus.address = 32'h400; bus.store_data = 32'h0BADF00D;
        last_load = 32'd0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            w = (i == 1) ? 32'h11223344 : (i == 2) ? 32'h80FF7F01 : $urandom;
            pl_en = 1'b1; pl_idx = 8'(i); pl_data = w;
            ref_b[4*i] = w[31:24]; ref_b[4*i+1] = w[23:16];
            ref_b[4*i+2] = w[15:8]; ref_b[4*i+3] = w[7:0];
            #1;
            if (i % 32 == 0) begin
                chk("rst_readEn", 32'(bus.dm_readEn), 32'd0);
                chk("rst_writeEn", 32'(bus.dm_writeEn), 32'd0);
                chk("rst_stall", 32'(bus.stall), 32'd0);
            end
        end
        @(negedge clk);
        pl_en = 1'b0;
        #1;
        chk("rst_load_data", bus.load_data, 32'd0);
        chk("rst_load_valid", 32'(bus.load_valid), 32'd0);
        chk("rst_misalign", 32'(bus.misalign_err), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 15; i++) begin
            do_req(1'b1, vecs[i].mr, vecs[i].mw, vecs[i].sz, vecs[i].sx, vecs[i].a, vecs[i].d, res, gs, gm);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
            chk($sformatf("vec%0d_stall", i), 32'(gs), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_misalign", i), 32'(gm), 32'(vecs[i].exp_mis));
        end

        // Reset during RMW_WRITE abandons the merged write
        @(negedge clk);
        bus.req_valid = 1'b1; bus.mem_read = 1'b0; bus.mem_write = 1'b1;
        bus.size = 2'd0; bus.address = 32'h404; bus.store_data = 32'h55;
        #1;
        chk("rmwrst_stall", 32'(bus.stall), 32'd1);
        chk("rmwrst_readEn", 32'(bus.dm_readEn), 32'd1);
        @(posedge clk); #1;
        chk("rmwrst_pre_writeEn", 32'(bus.dm_writeEn), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rmwrst_writeEn", 32'(bus.dm_writeEn), 32'd0);
        chk("rmwrst_stall_rst", 32'(bus.stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; bus.req_valid = 1'b0;
        last_load = 32'd0;
        chk("rmwrst_load_valid", 32'(bus.load_valid), 32'd0);
        @(negedge clk); #1;
        chk("rmwrst_after_writeEn", 32'(bus.dm_writeEn), 32'd0);
        chk("rmwrst_mem_word", tb_mem[1], 32'h1122AB44);
        do_req(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h404, 32'h0, res, gs, gm);
        chk("rmwrst_reload", res, 32'h1122AB44);

        // Random traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            rv = ($urandom % 6) != 0;
            case ($urandom % 3)
                0:       begin mr = 1'b1; mw = 1'b0; end
                1:       begin mr = 1'b0; mw = 1'b1; end
                default: begin mr = 1'b1; mw = 1'b1; end
            endcase
            sz = 2'($urandom % 4);
            sx = 1'($urandom % 2);
            a  = $urandom;
            d  = $urandom;
            if (($urandom % 4) != 0) begin
                if (sz == 2'd3) sz = 2'($urandom % 3);
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req(rv, mr, mw, sz, sx, a, d, res, gs, gm);
        end

        // Final memory image must equal the model
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        nbad = 0;
        for (int i = 0; i < 256; i++)
            if (tb_mem[i] !== {ref_b[4*i], ref_b[4*i+1], ref_b[4*i+2], ref_b[4*i+3]}) nbad++;
        chk("mem_image_bad_words", 32'(nbad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
